// File: rtl/uart_prog_loader.sv
// Receives an 8N1 program image on rx and writes it into program RAM, holding the CPU until the checksum checks out.
// Write latency: we pulses two cycles after the stop-bit sample; the byte stream has no backpressure.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 234,
  parameter int TIMEOUT_CLKS = 2700000,
  parameter bit RUN_AT_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       we,
  output logic [7:0] w_addr,
  output logic [7:0] w_data,
  output logic       cpu_run,
  output logic       loading,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {P_SYNC, P_LEN, P_DATA, P_SUM} p_state_t;

  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_t       r_state_q, r_state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_vld_q, byte_vld_d;
  logic            frm_err_q, frm_err_d;

  p_state_t        p_state_q, p_state_d;
  logic [7:0]      idx_q, idx_d;
  logic [8:0]      rem_q, rem_d;
  logic [7:0]      sum_q, sum_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            we_q, we_d;
  logic [7:0]      w_addr_q, w_addr_d;
  logic [7:0]      w_data_q, w_data_d;
  logic            cpu_run_q, cpu_run_d;
  logic            loading_q, loading_d;
  logic            err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      r_state_q  <= R_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      byte_vld_q <= 1'b0;
      frm_err_q  <= 1'b0;
      p_state_q  <= P_SYNC;
      idx_q      <= '0;
      rem_q      <= '0;
      sum_q      <= '0;
      tmo_q      <= '0;
      we_q       <= 1'b0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      cpu_run_q  <= RUN_AT_RESET;
      loading_q  <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      r_state_q  <= r_state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      byte_vld_q <= byte_vld_d;
      frm_err_q  <= frm_err_d;
      p_state_q  <= p_state_d;
      idx_q      <= idx_d;
      rem_q      <= rem_d;
      sum_q      <= sum_d;
      tmo_q      <= tmo_d;
      we_q       <= we_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
      cpu_run_q  <= cpu_run_d;
      loading_q  <= loading_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // Receiver: cnt_q paces the mid-bit sample points after the start edge.
  always_comb begin
    r_state_d  = r_state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_vld_d = 1'b0;
    frm_err_d  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          r_state_d = R_START;
          cnt_d     = '0;
        end
      end
      R_START: begin
        if (cnt_q == HALF_BIT) begin
          cnt_d     = '0;
          bit_d     = '0;
          r_state_d = rx_s2_q ? R_IDLE : R_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_DATA: begin
        if (cnt_q == FULL_BIT) begin
          cnt_d   = '0;
          shift_d = {rx_s2_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) r_state_d = R_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_STOP: begin
        if (cnt_q == FULL_BIT) begin
          cnt_d      = '0;
          byte_vld_d = rx_s2_q;
          frm_err_d  = !rx_s2_q;
          r_state_d  = R_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    p_state_d  = p_state_q;
    idx_d      = idx_q;
    rem_d      = rem_q;
    sum_d      = sum_q;
    we_d       = 1'b0;
    w_addr_d   = w_addr_q;
    w_data_d   = w_data_q;
    cpu_run_d  = cpu_run_q;
    loading_d  = loading_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    tmo_d      = (loading_q && !byte_vld_q) ? tmo_q + 1'b1 : '0;

    if (frm_err_q) begin
      err_d      = 1'b1;
      err_code_d = 2'b01;
      p_state_d  = P_SYNC;
      loading_d  = 1'b0;
    end else if (byte_vld_q) begin
      case (p_state_q)
        P_SYNC: begin
          if (shift_q == 8'hA5) begin
            loading_d = 1'b1;
            cpu_run_d = 1'b0;
            p_state_d = P_LEN;
          end
        end
        P_LEN: begin
          rem_d     = (shift_q == 8'h00) ? 9'd256 : {1'b0, shift_q};
          idx_d     = '0;
          sum_d     = '0;
          p_state_d = P_DATA;
        end
        P_DATA: begin
          we_d     = 1'b1;
          w_addr_d = idx_q;
          w_data_d = shift_q;
          idx_d    = idx_q + 1'b1;
          sum_d    = sum_q + shift_q;
          rem_d    = rem_q - 1'b1;
          if (rem_q == 9'd1) p_state_d = P_SUM;
        end
        P_SUM: begin
          loading_d = 1'b0;
          p_state_d = P_SYNC;
          if (shift_q == sum_q) begin
            cpu_run_d = 1'b1;
          end else begin
            err_d      = 1'b1;
            err_code_d = 2'b10;
          end
        end
        default: p_state_d = P_SYNC;
      endcase
    end else if (loading_q && tmo_q == TMO_LAST) begin
      err_d      = 1'b1;
      err_code_d = 2'b11;
      p_state_d  = P_SYNC;
      loading_d  = 1'b0;
      tmo_d      = '0;
    end
  end

  assign we       = we_q;
  assign w_addr   = w_addr_q;
  assign w_data   = w_data_q;
  assign cpu_run  = cpu_run_q;
  assign loading  = loading_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Drives framed images over rx and checks writes, error pulses and CPU hold against a byte-level protocol model.
module tb_uart_prog_loader;
  localparam int CPB = 4;
  localparam int TMO = 200;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       we;
  logic [7:0] w_addr, w_data;
  logic       cpu_run, loading, err;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO), .RUN_AT_RESET(1'b1)) dut (
    .clk(clk), .reset(reset), .rx(rx), .we(we), .w_addr(w_addr), .w_data(w_data),
    .cpu_run(cpu_run), .loading(loading), .err(err), .err_code(err_code)
  );

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [15:0] got_wr[$];
  logic [15:0] exp_wr[$];
  logic [1:0]  got_err[$];
  logic [1:0]  exp_err[$];

  always @(negedge clk) begin
    if (we) got_wr.push_back({w_addr, w_data});
    if (err) got_err.push_back(err_code);
  end

  // Byte-level reference model of the load protocol.
  int         mstate = 0;
  int         mrem = 0;
  logic [7:0] midx = 8'h00;
  logic [7:0] msum = 8'h00;
  bit         mcpu = 1'b1;
  bit         mload = 1'b0;
  logic [1:0] mcode = 2'b00;

  task automatic model_abort(input logic [1:0] code);
    exp_err.push_back(code);
    mcode = code;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      model_abort(2'b01);
      if (mload) begin
        mload  = 1'b0;
        mstate = 0;
      end
    end else begin
      case (mstate)
        0: if (b == 8'hA5) begin mload = 1'b1; mcpu = 1'b0; mstate = 1; end
        1: begin mrem = (b == 8'h00) ? 256 : int'(b); midx = 8'h00; msum = 8'h00; mstate = 2; end
        2: begin
          exp_wr.push_back({midx, b});
          midx = midx + 8'd1;
          msum = msum + b;
          mrem--;
          if (mrem == 0) mstate = 3;
        end
        default: begin
          if (b == msum) mcpu = 1'b1;
          else model_abort(2'b10);
          mload  = 1'b0;
          mstate = 0;
        end
      endcase
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic uart_tx(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(CPB);
    end
    rx = stop_ok;
    cyc(CPB);
    rx = 1'b1;
    cyc(CPB);
  endtask

  task automatic send(input logic [7:0] b, input bit ok);
    uart_tx(b, ok);
    model_byte(b, ok);
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".cpu_run"}, cpu_run, mcpu);
    chk({tag, ".loading"}, loading, mload);
  endtask

  task automatic compare(input string tag);
    int n;
    cyc(20);
    chk({tag, ".nwr"}, got_wr.size(), exp_wr.size());
    n = (got_wr.size() < exp_wr.size()) ? got_wr.size() : exp_wr.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s.wr%0d", tag, i), got_wr[i], exp_wr[i]);
    chk({tag, ".nerr"}, got_err.size(), exp_err.size());
    n = (got_err.size() < exp_err.size()) ? got_err.size() : exp_err.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s.err%0d", tag, i), got_err[i], exp_err[i]);
    check_status(tag);
    chk({tag, ".err_code"}, err_code, mcode);
    got_wr.delete(); exp_wr.delete(); got_err.delete(); exp_err.delete();
  endtask

  initial begin
    logic [7:0] b, sum;
    int         n;
    bit         aborted;

    reset = 1'b1;
    rx    = 1'b1;
    cyc(5);
    chk("rst.cpu_run", cpu_run, 1'b1);
    chk("rst.we", we, 1'b0);
    chk("rst.loading", loading, 1'b0);
    chk("rst.err_code", err_code, 2'b00);
    chk("rst.w_addr", w_addr, 8'h00);
    reset = 1'b0;
    cyc(5);

    send(8'hA5, 1); send(8'h03, 1);
    check_status("load3.mid");
    send(8'hB3, 1); send(8'h01, 1); send(8'hE0, 1); send(8'h94, 1);
    compare("load3");

    send(8'h37, 1); send(8'hA5, 1); send(8'h01, 1); send(8'h10, 1); send(8'h11, 1);
    compare("badsum");

    send(8'hA5, 1); send(8'h02, 1); send(8'h66, 1); send(8'h55, 0);
    compare("frame");
    chk("frame.hold_addr", w_addr, 8'h00);
    chk("frame.hold_data", w_data, 8'h66);

    send(8'hA5, 1); send(8'h04, 1); send(8'h01, 1);
    cyc(250);
    if (mload) begin
      model_abort(2'b11);
      mload  = 1'b0;
      mstate = 0;
    end
    compare("timeout");
    send(8'hA5, 1); send(8'h01, 1); send(8'h7F, 1); send(8'h7F, 1);
    compare("after_tmo");

    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(0, 2);
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        send(b, 1);
      end
      aborted = 1'b0;
      send(8'hA5, 1);
      n = $urandom_range(1, 12);
      send(8'(n), 1);
      sum = 8'h00;
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom);
        if (!aborted) begin
          if ($urandom_range(0, 15) == 0) begin
            send(b, 0);
            aborted = 1'b1;
          end else begin
            send(b, 1);
            sum = sum + b;
          end
        end
      end
      if (!aborted) begin
        if ($urandom_range(0, 1) == 1) sum = sum + 8'($urandom_range(1, 255));
        send(sum, 1);
      end
      compare($sformatf("rnd%0d", r));
    end

    send(8'hA5, 1); send(8'h00, 1);
    for (int j = 0; j < 256; j++) send(8'(j), 1);
    send(8'h80, 1);
    compare("full256");
    chk("full256.last_addr", w_addr, 8'hFF);

    send(8'hA5, 1); send(8'h05, 1); send(8'h11, 1); send(8'h22, 1);
    compare("prereset");
    rx = 1'b0;
    cyc(2 * CPB);
    reset = 1'b1;
    cyc(3);
    rx = 1'b1;
    cyc(1);
    reset = 1'b0;
    mstate = 0; mload = 1'b0; mcpu = 1'b1; mcode = 2'b00;
    cyc(3 * CPB);
    send(8'h33, 1); send(8'h44, 1);
    compare("midreset");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
